cdc_toggle_handshake_receiver: RTL and testbench
================================================

// Module: cdc_toggle_handshake_receiver
//
// PURPOSE
//   Receive side of a toggle-based request/acknowledge clock-domain crossing.
//   Sits directly downstream of the double-flop request synchronizer.
//   - Detects each toggle on the synchronized request.
//   - Captures the quasi-static data bus the sender holds stable.
//   - Presents the word to a local valid/ready consumer.
//   - Toggles an acknowledge back to the sender domain once the word is consumed.
//
// PARAMETERS
//   WIDTH  8  width of the crossed data word, in bits
//
// PORTS
//   clk             in   1      receive-domain clock
//   rst             in   1      synchronous, active-high reset
//   req_toggle_sync in   1      request toggle, already double-flop synchronized to clk
//   data_in         in   WIDTH  sender data; held stable from its req toggle until it sees the ack
//   ack_toggle      out  1      acknowledge toggle back to the sender; registered, glitch-free
//   out_data        out  WIDTH  captured word
//   out_valid       out  1      out_data holds an unconsumed word
//   out_ready       in   1      consumer accepts out_data when out_valid & out_ready
//   protocol_error  out  1      sticky violation flag; present only with CDC_RX_PROTOCOL_CHECK_EN
//
// BEHAVIOUR
//   Single clock domain: clk. Reset rst is synchronous and active-high.
//   - Reset values: ack_toggle=0, out_valid=0, out_data=0, protocol_error=0,
//     internal req_prev=0, state=IDLE.
//   - Reset mid-transfer discards the held word; no ack is produced for it.
//   - System rule: both domains are reset together.
//   - Edge detect: req_edge = req_toggle_sync ^ req_prev.
//     req_prev <= req_toggle_sync every cycle out of reset.
//   - FSM, two states:
//     - IDLE: out_valid=0.
//       On req_edge: out_data <= data_in, go to HOLD.
//       out_valid is high the cycle after the edge is seen (latency 1 from req_toggle_sync).
//     - HOLD: out_valid=1; out_data is stable.
//       On out_valid & out_ready: ack_toggle <= ~ack_toggle and go to IDLE.
//       The ack toggle is visible the cycle after the handshake.
//   - data_in is sampled only in the IDLE state, on the clock edge where req_edge=1.
//     It is never sampled at any other time, so multi-bit skew is safe by protocol.
//   - Back-to-back: a req_edge in the first IDLE cycle after an ack is accepted normally.
//     In practice the sender round trip makes this at least about 4 cycles.
//   - req_edge while in HOLD is a protocol violation (sender toggled before the ack):
//     - The edge is dropped.
//     - The held word and out_valid are unaffected.
//     - The FSM stays in HOLD.
//   - out_ready is ignored in IDLE. out_valid never drops without a handshake, except on reset.
//   - Exactly one ack toggle per accepted word; ack_toggle never toggles in IDLE.
//
// CONFIGURATION
//   CDC_RX_PROTOCOL_CHECK_EN
//   - Defined:
//     - Port protocol_error exists.
//     - It is set on a req_edge while in HOLD, and also on a req_edge in the same cycle
//       as the ack handshake.
//     - It is sticky until rst.
//     - Simulation-only $error on the same condition.
//   - Undefined:
//     - Port and logic are absent.
//     - Violations silently drop the edge, with the data path behaving identically.
//
// TESTING
//   1. Reset, req_toggle_sync 0->1, data_in=8'hA5, out_ready=1
//      -> next cycle out_valid=1, out_data=A5; following cycle out_valid=0, ack_toggle=1.
//   2. Toggle with out_ready=0 for 5 cycles, data_in changed to 8'h3C after capture
//      -> out_valid held high, out_data stays A5, ack_toggle static;
//         ready=1 -> ack toggles once, one cycle later.
//   3. Four words 01,02,03,04, each sent after the previous ack
//      -> consumer sees 01..04 in order, ack_toggle ends at 0, no extra valids.
//   4. Second req toggle while in HOLD (EN defined)
//      -> protocol_error=1 sticky, out_data unchanged, one ack only;
//         with EN undefined, the same data-path result.
//   5. rst asserted in HOLD
//      -> next cycle out_valid=0, ack_toggle=0, out_data=0, protocol_error=0;
//         a fresh toggle after reset is received normally.
//   6. Handshake cycle coincides with a new req toggle
//      -> the edge is dropped (flagged if EN), FSM returns to IDLE, ack toggles exactly once.

Source files
------------

// File: rtl/cdc_toggle_handshake_receiver_if.sv
// Handshake/bus bundle for the toggle-based CDC receiver.
// The master side is the sender plus the local consumer.
// The slave side is the receiver itself.
interface cdc_toggle_handshake_receiver_if #(
    parameter int WIDTH = 8
);
    logic             req_toggle_sync;
    logic [WIDTH-1:0] data_in;
    logic             ack_toggle;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output req_toggle_sync,
        output data_in,
        output out_ready,
        input  ack_toggle,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  req_toggle_sync,
        input  data_in,
        input  out_ready,
        output ack_toggle,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/cdc_toggle_handshake_receiver.sv
// Receive side of a toggle request/acknowledge clock-domain crossing.
// Each toggle of the synchronized request captures the sender's quasi-static word.
// The word is offered on a valid/ready port, and the ack is toggled back once it is consumed.
// Optional macro CDC_RX_PROTOCOL_CHECK_EN adds a sticky protocol_error output.
// That output flags request toggles that arrive while a word is still held.
module cdc_toggle_handshake_receiver #(
    parameter int WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    cdc_toggle_handshake_receiver_if.slave        bus
`ifdef CDC_RX_PROTOCOL_CHECK_EN
    ,
    output logic                                  protocol_error
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic             req_prev;
    logic             req_edge;
    logic             ack_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A new request is any change of the synchronized toggle since last cycle
    assign req_edge = bus.req_toggle_sync ^ req_prev;

    assign bus.ack_toggle = ack_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;

    // Capture on a request edge in IDLE, and hold until the consumer takes the word
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_prev <= 1'b0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            req_prev <= bus.req_toggle_sync;
            case (state)
                IDLE: begin
                    if (req_edge) begin
                        data_q  <= bus.data_in;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        ack_q   <= ~ack_q;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef CDC_RX_PROTOCOL_CHECK_EN
    // Any request edge seen while a word is held, including on the handshake cycle, is a violation
    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_error <= 1'b0;
        end else if (state == HOLD && req_edge) begin
            protocol_error <= 1'b1;
`ifndef SYNTHESIS
            $error("cdc_toggle_handshake_receiver: request toggled before ack");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_cdc_toggle_handshake_receiver.sv
// Self-checking bench for cdc_toggle_handshake_receiver.
// Directed scenarios are followed by randomized sender/consumer traffic.
// Everything is compared against a transaction-level reference model.
module tb_cdc_toggle_handshake_receiver;

    logic clk;
    logic rst;
`ifdef CDC_RX_PROTOCOL_CHECK_EN
    logic protocol_error;
`endif

    cdc_toggle_handshake_receiver_if #(.WIDTH(8)) bus ();

    cdc_toggle_handshake_receiver #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave)
`ifdef CDC_RX_PROTOCOL_CHECK_EN
        ,
        .protocol_error (protocol_error)
`endif
    );

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state: is a word pending, what is it, how many acks sent
    bit       m_pending;
    bit [7:0] m_word;
    int       m_acks;
    bit       m_last_req;
    bit       m_violation;
    int       m_delivered;
    bit [7:0] sent_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs present at the edge,
    // then compare all outputs away from the edge.
    task automatic step(input string tag);
        bit req_changed;
        @(posedge clk);
        req_changed = (bus.req_toggle_sync != m_last_req);
        m_last_req  = bus.req_toggle_sync;
        if (rst) begin
            m_pending   = 0;
            m_word      = 8'h00;
            m_acks      = 0;
            m_last_req  = 0;
            m_violation = 0;
            sent_q.delete();
        end else if (m_pending) begin
            if (req_changed) m_violation = 1;
            if (bus.out_ready) begin
                m_pending = 0;
                m_acks++;
                m_delivered++;
                if (sent_q.size() > 0) begin
                    checkOutput({tag, "_order"}, {24'h0, m_word}, {24'h0, sent_q.pop_front()});
                end
            end
        end else if (req_changed) begin
            m_pending = 1;
            m_word    = bus.data_in;
        end
        @(negedge clk);
        checkOutput({tag, "_valid"}, {31'h0, bus.out_valid}, {31'h0, m_pending});
        checkOutput({tag, "_data"}, {24'h0, bus.out_data}, {24'h0, m_word});
        checkOutput({tag, "_ack"}, {31'h0, bus.ack_toggle}, {31'h0, m_acks[0]});
`ifdef CDC_RX_PROTOCOL_CHECK_EN
        checkOutput({tag, "_perr"}, {31'h0, protocol_error}, {31'h0, m_violation});
`endif
    endtask

    // Drive one cycle of inputs; a toggle into an idle receiver is recorded as a legal word
    task automatic applyStimulus(input string tag, input logic r, input logic q,
                                 input logic [7:0] d, input logic rdy);
        if (!r && !m_pending && q != m_last_req) sent_q.push_back(d);
        rst                 = r;
        bus.req_toggle_sync = q;
        bus.data_in         = d;
        bus.out_ready       = rdy;
        step(tag);
    endtask

    initial begin
        logic q;
        int   acks_before;
        m_pending   = 0;
        m_word      = 0;
        m_acks      = 0;
        m_last_req  = 0;
        m_violation = 0;
        m_delivered = 0;
        rst                 = 1'b1;
        bus.req_toggle_sync = 1'b0;
        bus.data_in         = 8'h00;
        bus.out_ready       = 1'b0;

        // 1: reset, then a single word consumed immediately
        applyStimulus("t1_rst", 1, 0, 8'h00, 0);
        checkOutput("t1_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("t1_rst_ack", {31'h0, bus.ack_toggle}, 32'h0);
        checkOutput("t1_rst_data", {24'h0, bus.out_data}, 32'h0);
        applyStimulus("t1_cap", 0, 1, 8'hA5, 1);
        checkOutput("t1_cap_valid", {31'h0, bus.out_valid}, 32'h1);
        checkOutput("t1_cap_data", {24'h0, bus.out_data}, 32'hA5);
        applyStimulus("t1_hs", 0, 1, 8'hA5, 1);
        checkOutput("t1_hs_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("t1_hs_ack", {31'h0, bus.ack_toggle}, 32'h1);

        // 2: backpressure for five cycles while the sender's bus changes
        applyStimulus("t2_cap", 0, 0, 8'hA5, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("t2_hold", 0, 0, 8'h3C, 0);
            checkOutput("t2_hold_data", {24'h0, bus.out_data}, 32'hA5);
            checkOutput("t2_hold_ack", {31'h0, bus.ack_toggle}, 32'h1);
        end
        applyStimulus("t2_hs", 0, 0, 8'h3C, 1);
        checkOutput("t2_hs_ack", {31'h0, bus.ack_toggle}, 32'h0);

        // 3: four words, each sent after the previous ack
        q = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            q = ~q;
            applyStimulus("t3_cap", 0, q, 8'(i), 1);
            checkOutput("t3_word", {24'h0, bus.out_data}, i);
            applyStimulus("t3_hs", 0, q, 8'(i), 1);
        end
        applyStimulus("t3_idle", 0, q, 8'hFF, 1);
        checkOutput("t3_end_ack", {31'h0, bus.ack_toggle}, 32'h0);
        checkOutput("t3_end_valid", {31'h0, bus.out_valid}, 32'h0);

        // 4: a second toggle while the word is held is dropped
        q = ~q;
        applyStimulus("t4_cap", 0, q, 8'h77, 0);
        q = ~q;
        applyStimulus("t4_viol", 0, q, 8'h88, 0);
        applyStimulus("t4_hold", 0, q, 8'h88, 0);
        checkOutput("t4_keep_data", {24'h0, bus.out_data}, 32'h77);
        applyStimulus("t4_hs", 0, q, 8'h88, 1);
        applyStimulus("t4_after", 0, q, 8'h88, 1);
        checkOutput("t4_no_extra_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("t4_one_ack", {31'h0, bus.ack_toggle}, 32'h1);
`ifdef CDC_RX_PROTOCOL_CHECK_EN
        checkOutput("t4_perr_sticky", {31'h0, protocol_error}, 32'h1);
`endif

        // 5: reset while holding a word; both domains return to zero
        q = ~q;
        applyStimulus("t5_cap", 0, q, 8'h5A, 0);
        applyStimulus("t5_rst", 1, 0, 8'h5A, 0);
        checkOutput("t5_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("t5_rst_data", {24'h0, bus.out_data}, 32'h0);
        checkOutput("t5_rst_ack", {31'h0, bus.ack_toggle}, 32'h0);
`ifdef CDC_RX_PROTOCOL_CHECK_EN
        checkOutput("t5_rst_perr", {31'h0, protocol_error}, 32'h0);
`endif
        q = 1'b1;
        applyStimulus("t5_fresh", 0, q, 8'hC3, 0);
        checkOutput("t5_fresh_data", {24'h0, bus.out_data}, 32'hC3);
        applyStimulus("t5_hs", 0, q, 8'hC3, 1);

        // 6: handshake cycle coincides with a new request toggle
        q = ~q;
        applyStimulus("t6_cap", 0, q, 8'h96, 0);
        acks_before = m_acks;
        q = ~q;
        applyStimulus("t6_hs", 0, q, 8'h69, 1);
        applyStimulus("t6_after", 0, q, 8'h69, 1);
        applyStimulus("t6_after2", 0, q, 8'h69, 1);
        checkOutput("t6_dropped", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("t6_one_ack", m_acks - acks_before, 32'h1);

        // Randomized traffic with occasional protocol violations and resets
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 99) == 0);
            if (r) q = 1'b0;
            else if ($urandom_range(0, 4) == 0) q = ~q;
            applyStimulus("rnd", r, q, 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        // Drain whatever is still held
        for (int i = 0; i < 3; i++) applyStimulus("drain", 0, q, 8'h00, 1);
        checkOutput("drain_idle", {31'h0, bus.out_valid}, 32'h0);

        $display("[TB] words delivered: %0d", m_delivered);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
